// File: rtl/step_dir_counter.sv
// step_dir_counter: deglitched step/direction receiver with a running
// position and a per-period sign-magnitude step count.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   pulse_in  async step input, one step per rising edge
//   dir_in    async direction, 1 = down, 0 = up
//   sync      one-cycle period restart strobe
//   position  signed running position, wraps
//   n_out     last period count {sign, sat magnitude[6:0]}
//   n_valid   one-cycle strobe when n_out updates
//   sat       sticky: some published magnitude exceeded 127
module step_dir_counter #(
   parameter int PERIOD_CYCLES = 20000,
   parameter int FILT_LEN      = 4,
   parameter int POS_W         = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pulse_in,
   input  logic                    dir_in,
   input  logic                    sync,
   output logic signed [POS_W-1:0] position,
   output logic [7:0]              n_out,
   output logic                    n_valid,
   output logic                    sat
);

   localparam logic [3:0]       FILT_MAX = 4'(FILT_LEN - 1);
   localparam logic [15:0]      TERM     = 16'(PERIOD_CYCLES - 1);
   localparam logic [POS_W-1:0] ONE      = POS_W'(1);

   logic              p_s1;
   logic              p_s2;
   logic              d_s1;
   logic              d_s2;
   logic              filt;
   logic              filt_d;
   logic [3:0]        fcnt;
   logic [15:0]       timer;
   logic signed [15:0] acc;

   logic              step;
   logic              terminal;
   logic signed [16:0] acc_sum;
   logic signed [15:0] acc_nxt;
   logic [15:0]       acc_abs;
   logic [14:0]       mag;
   logic [7:0]        n_nxt;

   always_comb begin
      step     = filt & ~filt_d;
      terminal = (timer == TERM);
      acc_sum  = {acc[15], acc};
      if (step) begin
         if (d_s2)
            acc_sum = acc_sum - 17'sd1;
         else
            acc_sum = acc_sum + 17'sd1;
      end
      // Clamp symmetrically so the magnitude always fits 15 bits.
      if (acc_sum > 17'sd32767)
         acc_nxt = 16'sd32767;
      else if (acc_sum < -17'sd32767)
         acc_nxt = -16'sd32767;
      else
         acc_nxt = acc_sum[15:0];
      acc_abs = acc_nxt[15] ? 16'(-acc_nxt) : 16'(acc_nxt);
      mag     = acc_abs[14:0];
      // Sign bit comes from a nonzero negative value only,
      // so a zero count never shows up as 8'h80.
      n_nxt   = {acc_nxt[15], (mag > 15'd127) ? 7'h7F : mag[6:0]};
   end

   // Input synchronizers and pulse filter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_s1   <= 1'b0;
         p_s2   <= 1'b0;
         d_s1   <= 1'b0;
         d_s2   <= 1'b0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
         fcnt   <= 4'd0;
      end else begin
         p_s1   <= pulse_in;
         p_s2   <= p_s1;
         d_s1   <= dir_in;
         d_s2   <= d_s1;
         filt_d <= filt;
         if (p_s2 == filt) begin
            fcnt <= 4'd0;
         end else if (fcnt == FILT_MAX) begin
            filt <= p_s2;
            fcnt <= 4'd0;
         end else begin
            fcnt <= fcnt + 4'd1;
         end
      end
   end

   // Position counter, unaffected by sync or saturation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         position <= '0;
      end else if (step) begin
         if (d_s2)
            position <= position - ONE;
         else
            position <= position + ONE;
      end
   end

   // Period timer, accumulator and publish.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer   <= 16'd0;
         acc     <= 16'sd0;
         n_out   <= 8'h00;
         n_valid <= 1'b0;
         sat     <= 1'b0;
      end else begin
         n_valid <= 1'b0;
         if (sync) begin
            timer <= 16'd0;
            acc   <= 16'sd0;
         end else if (terminal) begin
            timer   <= 16'd0;
            acc     <= 16'sd0;
            n_out   <= n_nxt;
            n_valid <= 1'b1;
            if (mag > 15'd127)
               sat <= 1'b1;
         end else begin
            timer <= timer + 16'd1;
            acc   <= acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_step_dir_counter.sv
// Bench for step_dir_counter: directed and random step streams
// checked against an event-level position/period-count model.
module tb_step_dir_counter;

   localparam int P = 4000;
   localparam int F = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pulse_in = 1'b0;
   logic dir_in = 1'b0;
   logic sync = 1'b0;

   logic signed [31:0] position;
   logic [7:0]         n_out;
   logic               n_valid;
   logic               sat;
   logic signed [7:0]  pos_w;
   logic [7:0]         n_out_w;
   logic               n_valid_w;
   logic               sat_w;

   int checks = 0;
   int errors = 0;
   int ecount = 0;
   int t0 = 0;

   longint     mpos = 0;
   int         macc = 0;
   bit         msat = 1'b0;
   logic [7:0] last_n = 8'h00;

   step_dir_counter #(
      .PERIOD_CYCLES(P), .FILT_LEN(F), .POS_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in),
      .dir_in(dir_in), .sync(sync), .position(position),
      .n_out(n_out), .n_valid(n_valid), .sat(sat)
   );

   step_dir_counter #(
      .PERIOD_CYCLES(P), .FILT_LEN(F), .POS_W(8)
   ) dut_w (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in),
      .dir_in(dir_in), .sync(sync), .position(pos_w),
      .n_out(n_out_w), .n_valid(n_valid_w), .sat(sat_w)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecount <= ecount + 1;

   function automatic logic [7:0] pub(int a);
      int m;
      m = (a < 0) ? -a : a;
      if (m > 127) m = 127;
      return {(a < 0) ? 1'b1 : 1'b0, m[6:0]};
   endfunction

   task automatic chk(string tag, logic [63:0] obs,
                      logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_pos(string tag);
      chk({tag, "_pos"}, 64'($unsigned(position)),
          64'(mpos[31:0]));
      chk({tag, "_posw"}, 64'($unsigned(pos_w)),
          64'(mpos[7:0]));
   endtask

   task automatic do_step(bit d, int h, int l);
      if (dir_in !== d) begin
         dir_in = d;
         cyc(3);
      end
      pulse_in = 1'b1;
      cyc(h);
      pulse_in = 1'b0;
      cyc(l);
      mpos += d ? -1 : 1;
      macc += d ? -1 : 1;
   endtask

   task automatic do_sync();
      sync = 1'b1;
      cyc(1);
      sync = 1'b0;
      macc = 0;
      t0 = ecount;
   endtask

   task automatic wait_pub(string tag);
      bit held;
      logic [7:0] e;
      held = 1'b1;
      cyc(1);
      while (n_valid !== 1'b1 && (ecount - t0) < P + 20) begin
         if (n_out !== last_n || sat !== msat) held = 1'b0;
         cyc(1);
      end
      chk({tag, "_period"}, 64'(ecount - t0), 64'(P));
      chk({tag, "_hold"}, 64'(held), 64'(1));
      e = pub(macc);
      if (macc > 127 || macc < -127) msat = 1'b1;
      chk({tag, "_nout"}, 64'(n_out), 64'(e));
      chk({tag, "_noutw"}, 64'(n_out_w), 64'(e));
      chk({tag, "_nvw"}, 64'(n_valid_w), 64'(1));
      chk({tag, "_sat"}, 64'(sat), 64'(msat));
      chk({tag, "_satw"}, 64'(sat_w), 64'(msat));
      chk_pos(tag);
      last_n = e;
      macc = 0;
      t0 = ecount;
   endtask

   initial begin
      int n;
      bit d;

      // Reset and idle periods.
      cyc(5);
      chk("rst_pos", 64'(position), 64'(0));
      chk("rst_nout", 64'(n_out), 64'(0));
      chk("rst_nv", 64'(n_valid), 64'(0));
      chk("rst_sat", 64'(sat), 64'(0));
      rst_n = 1'b1;
      t0 = ecount;
      wait_pub("idle1");
      wait_pub("idle2");

      // Forward count.
      do_sync();
      repeat (50) do_step(1'b0, 10, 10);
      wait_pub("fwd");

      // Reverse and mixed.
      do_sync();
      repeat (30) do_step(1'b0, $urandom_range(5, 8),
                          $urandom_range(5, 8));
      repeat (45) do_step(1'b1, $urandom_range(5, 8),
                          $urandom_range(5, 8));
      wait_pub("mixed");

      // Glitch rejection, latency, low-going dip.
      do_sync();
      dir_in = 1'b0;
      cyc(3);
      for (int g = 1; g < F; g++) begin
         pulse_in = 1'b1;
         cyc(g);
         pulse_in = 1'b0;
         cyc(12);
         chk_pos("glitch");
      end
      pulse_in = 1'b1;
      cyc(F + 2);
      pulse_in = 1'b0;
      chk_pos("lat_early");
      cyc(1);
      mpos++;
      macc++;
      chk_pos("lat_edge");
      cyc(10);
      pulse_in = 1'b1;
      cyc(12);
      pulse_in = 1'b0;
      cyc(2);
      pulse_in = 1'b1;
      cyc(12);
      pulse_in = 1'b0;
      cyc(12);
      mpos++;
      macc++;
      chk_pos("dip");
      wait_pub("glitch");

      // Saturation, then a small period with sat still set.
      do_sync();
      repeat (200) do_step(1'b0, $urandom_range(5, 7),
                           $urandom_range(5, 7));
      wait_pub("sat1");
      repeat (3) do_step(1'b0, 8, 8);
      wait_pub("sat2");

      // Random periods.
      repeat (2) begin
         do_sync();
         n = $urandom_range(0, 120);
         repeat (n) begin
            d = 1'($urandom_range(0, 1));
            do_step(d, $urandom_range(5, 8),
                    $urandom_range(5, 8));
         end
         wait_pub("rand");
      end

      // Step counted on the terminal cycle.
      dir_in = 1'b1;
      cyc(P - 3 - F);
      pulse_in = 1'b1;
      mpos--;
      macc--;
      cyc(6);
      wait_pub("term_step");
      cyc(2);
      pulse_in = 1'b0;
      cyc(10);

      // Step one cycle after the terminal lands in the next period.
      dir_in = 1'b0;
      cyc(P - 2 - F - 12);
      pulse_in = 1'b1;
      cyc(5);
      wait_pub("late_step");
      cyc(3);
      pulse_in = 1'b0;
      mpos++;
      macc++;
      cyc(10);
      wait_pub("late_next");

      // sync on the terminal cycle suppresses the publish.
      repeat (3) do_step(1'b1, 6, 6);
      while ((ecount - t0) < P - 1) cyc(1);
      sync = 1'b1;
      cyc(1);
      chk("sync_term_nv", 64'(n_valid), 64'(0));
      chk("sync_term_nout", 64'(n_out), 64'(last_n));
      sync = 1'b0;
      macc = 0;
      t0 = ecount;
      wait_pub("after_sync");

      // Reset mid-period drops the partial count and sat.
      repeat (5) do_step(1'b0, 6, 6);
      cyc(10);
      rst_n = 1'b0;
      cyc(3);
      chk("mrst_pos", 64'(position), 64'(0));
      chk("mrst_nout", 64'(n_out), 64'(0));
      chk("mrst_sat", 64'(sat), 64'(0));
      chk("mrst_nv", 64'(n_valid), 64'(0));
      mpos = 0;
      macc = 0;
      msat = 1'b0;
      last_n = 8'h00;
      rst_n = 1'b1;
      t0 = ecount;
      wait_pub("post_reset");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
